ip_sound_dsm: RTL

Downstream audio stage for the SCC sound path: takes the signed 11-bit `sound_out` sample produced by `ip_ikascc_wrapper` and converts it to a 1-bit first-order delta-sigma stream for an external RC-filtered pin. It latches samples using the wrapper's `mclk_pcen_n` enable. A gain-ramp state machine fades audio in after reset or unmute and fades it out on mute, so the output never steps abruptly.

---
 rtl/ip_sound_dsm.sv | 98 +++++++++
 1 files changed

// File: rtl/ip_sound_dsm.sv
// ip_sound_dsm: gain-ramped first-order delta-sigma DAC for the SCC sound sample.
// Fades audio in/out through a 0..256 gain so the output never steps abruptly.
module ip_sound_dsm #(
  parameter int RAMP_SHIFT = 6
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               mclk_pcen_n,
  input  logic signed [10:0] sound_in,
  input  logic               mute,
  output logic               dac_out,
  output logic               ramp_busy
);
  localparam int PW = RAMP_SHIFT > 0 ? RAMP_SHIFT : 1;
  localparam logic [PW-1:0] PMAX = PW'((1 << RAMP_SHIFT) - 1);
  typedef enum logic [1:0] {MUTED, UP, ON, DOWN} state_e;
  state_e             state_q;
  logic [8:0]         g_q;
  logic [PW-1:0]      pre_q;
  logic signed [10:0] smp_q, scl_q, scl_d;
  logic signed [20:0] prod;
  logic [10:0]        acc_q, u;
  logic [11:0]        sum;
  logic               step;
  // With RAMP_SHIFT=0 the prescaler is degenerate and every ramp cycle is a step.
  assign step  = (RAMP_SHIFT == 0) || (pre_q == PMAX);
  assign prod  = smp_q * $signed({1'b0, g_q});
  assign scl_d = 11'(prod >>> 8);
  assign u     = {~scl_q[10], scl_q[9:0]};
  assign sum   = {1'b0, acc_q} + {1'b0, u};
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      state_q   <= MUTED;
      g_q       <= '0;
      pre_q     <= '0;
      ramp_busy <= 1'b0;
    end else begin
      case (state_q)
        MUTED: begin
          pre_q <= '0;
          if (!mute) begin
            state_q   <= UP;
            ramp_busy <= 1'b1;
          end
        end
        ON: begin
          pre_q <= '0;
          if (mute) begin
            state_q   <= DOWN;
            ramp_busy <= 1'b1;
          end
        end
        UP:
          if (mute) begin
            state_q <= DOWN;
            pre_q   <= '0;
          end else begin
            pre_q <= pre_q + 1'b1;
            if (step) begin
              g_q <= g_q + 9'd1;
              if (g_q == 9'd255) begin
                state_q   <= ON;
                ramp_busy <= 1'b0;
                pre_q     <= '0;
              end
            end
          end
        DOWN:
          if (!mute) begin
            state_q <= UP;
            pre_q   <= '0;
          end else begin
            pre_q <= pre_q + 1'b1;
            if (step) begin
              g_q <= g_q - 9'd1;
              if (g_q == 9'd1) begin
                state_q   <= MUTED;
                ramp_busy <= 1'b0;
                pre_q     <= '0;
              end
            end
          end
      endcase
    end
  // Offset binary u feeds an 11b accumulator; its carry is the pulse-density bit.
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      smp_q   <= '0;
      scl_q   <= '0;
      acc_q   <= '0;
      dac_out <= 1'b0;
    end else begin
      if (!mclk_pcen_n) smp_q <= sound_in;
      scl_q   <= scl_d;
      acc_q   <= sum[10:0];
      dac_out <= sum[11];
    end
endmodule
